// File: rtl/bus_slave_mux_wdt_pkg.sv
// Shared definitions for the slave response multiplexer and its bus watchdog.
package bus_slave_mux_wdt_pkg;

    localparam int WORD_DATA_W = 32;
    localparam int IDX_W_DEF   = 4;

    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_TOUT = 2'd2
    } wdt_state_e;

    // A disabled watchdog (timeout 0) still needs a 1-bit counter to stay legal.
    function automatic int wdt_cnt_width(input int timeout);
        return (timeout > 0) ? $clog2(timeout + 1) : 1;
    endfunction

endpackage

// File: rtl/bus_prio_enc.sv
// Active-low chip-select priority encoder: lowest asserted index wins.
module bus_prio_enc
    import bus_slave_mux_wdt_pkg::*;
#(
    parameter int N     = 8,
    parameter int IDX_W = IDX_W_DEF
) (
    input  logic [N-1:0]     cs_n_i,
    output logic [IDX_W-1:0] sel_o,
    output logic             any_o,
    output logic             multi_o
);

    // Scan from the top so the lowest asserted index is the last one written.
    always_comb begin
        sel_o   = '0;
        any_o   = 1'b0;
        multi_o = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            sel_o   = (cs_n_i[i] == ENABLE_) ? IDX_W'(i) : sel_o;
            multi_o = multi_o | (any_o & (cs_n_i[i] == ENABLE_));
            any_o   = any_o | (cs_n_i[i] == ENABLE_);
        end
    end

endmodule

// File: rtl/bus_slave_mux_wdt.sv
// Fixed-priority slave read-data/ready multiplexer with a bus watchdog that
// forces an error-terminated response, plus sticky error status.
module bus_slave_mux_wdt
    import bus_slave_mux_wdt_pkg::*;
#(
    parameter int NUM_SLAVES = 8,
    parameter int DATA_W     = WORD_DATA_W,
    parameter int TIMEOUT    = 255,
    parameter int IDX_W      = IDX_W_DEF
) (
    input  logic                         clk,
    input  logic                         reset_,
    input  logic [NUM_SLAVES-1:0]        s_cs_,
    input  logic [NUM_SLAVES*DATA_W-1:0] s_rd_data,
    input  logic [NUM_SLAVES-1:0]        s_rdy_,
    output logic [DATA_W-1:0]            m_rd_data,
    output logic                         m_rdy_,
    output logic                         m_err,
    input  logic                         err_clr,
    output logic                         sts_tout,
    output logic                         sts_multi,
    output logic [IDX_W-1:0]             sts_tout_idx
);

    localparam int CNT_W = wdt_cnt_width(TIMEOUT);
    localparam int CNT_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_LAST_I);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [IDX_W-1:0]  sel_s;
    logic              any_cs_s;
    logic              multi_s;
    logic [DATA_W-1:0] slice_data_s;
    logic              slice_rdy_s;
    logic              waiting_s;
    logic [CNT_W-1:0]  waited_s;

    wdt_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  sel_q;
    logic              m_err_q, m_err_d;
    logic              sts_tout_q, sts_tout_d;
    logic              sts_multi_q, sts_multi_d;
    logic [IDX_W-1:0]  sts_idx_q, sts_idx_d;

    bus_prio_enc #(
        .N     (NUM_SLAVES),
        .IDX_W (IDX_W)
    ) u_prio_enc (
        .cs_n_i  (s_cs_),
        .sel_o   (sel_s),
        .any_o   (any_cs_s),
        .multi_o (multi_s)
    );

    // Route the selected slave's data and ready.
    always_comb begin
        slice_data_s = '0;
        slice_rdy_s  = DISABLE_;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            slice_data_s = (sel_s == IDX_W'(i)) ? s_rd_data[i*DATA_W +: DATA_W] : slice_data_s;
            slice_rdy_s  = (sel_s == IDX_W'(i)) ? s_rdy_[i] : slice_rdy_s;
        end
    end

    // State register, wait counter and previous-cycle select.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sel_q   <= '0;
            m_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_s;
            m_err_q <= m_err_d;
        end
    end

    // Next state: cnt holds the number of earlier waiting cycles, so the
    // forced response lands in the (TIMEOUT+1)-th consecutive waiting cycle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        waiting_s = any_cs_s & (slice_rdy_s == DISABLE_);
        waited_s  = ((state_q == ST_WAIT) && (sel_s == sel_q)) ? cnt_q : '0;
        case (state_q)
            ST_IDLE, ST_WAIT: begin
                if (!any_cs_s) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (!waiting_s) begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                end else if ((TIMEOUT != 0) && (waited_s == CNT_LAST)) begin
                    state_d = ST_TOUT;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_WAIT;
                    cnt_d   = (waited_s == CNT_MAX) ? waited_s : waited_s + CNT_W'(1);
                end
            end
            ST_TOUT: begin
                state_d = any_cs_s ? ST_WAIT : ST_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Master response: forced termination overrides the slave in TOUT.
    always_comb begin
        m_err_d = (state_d == ST_TOUT);
        if (state_q == ST_TOUT) begin
            m_rd_data = '0;
            m_rdy_    = ENABLE_;
        end else if (any_cs_s) begin
            m_rd_data = slice_data_s;
            m_rdy_    = slice_rdy_s;
        end else begin
            m_rd_data = '0;
            m_rdy_    = DISABLE_;
        end
    end

    // Sticky status next values; a new event beats a coincident clear.
    always_comb begin
        sts_tout_d  = (state_q == ST_TOUT) ? 1'b1 : (err_clr ? 1'b0 : sts_tout_q);
        sts_multi_d = multi_s ? 1'b1 : (err_clr ? 1'b0 : sts_multi_q);
        sts_idx_d   = (state_q == ST_TOUT) ? sel_q : sts_idx_q;
    end

    // Sticky status registers.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            sts_tout_q  <= 1'b0;
            sts_multi_q <= 1'b0;
            sts_idx_q   <= '0;
        end else begin
            sts_tout_q  <= sts_tout_d;
            sts_multi_q <= sts_multi_d;
            sts_idx_q   <= sts_idx_d;
        end
    end

    assign m_err        = m_err_q;
    assign sts_tout     = sts_tout_q;
    assign sts_multi    = sts_multi_q;
    assign sts_tout_idx = sts_idx_q;

endmodule
